cond_ctrl_pipe: RTL and testbench

- Parametrised successor to the pipelined processor's controller and condition logic.
- Takes decoded control bits from the D stage and carries them through the E, M and W pipeline registers.
- Evaluates the ARM condition field in E against a flag register that supports a configurable number of flag-write groups.
- Gates side-effecting controls, handles stall and flush, and keeps saturating counters of annulled and retired instructions.

---
 rtl/cond_pkg.sv | 34 +++
 rtl/cond_check.sv | 39 +++
 rtl/cond_ctrl_pipe.sv | 167 ++++++++++++++++
 tb/tb_cond_ctrl_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared types for the conditional-execution controller: ARM condition codes,
// NZCV bit positions and the control bundle carried through the E/M/W registers.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic       valid;
    logic       pcs;
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       branch;
    logic       bl;
    logic       byteen;
    logic       alusrc;
    logic [3:0] alucontrol;
    cond_e      cond;
    logic [3:0] wa;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation: condition field + NZCV -> pass.
// No state, no latency; NV (4'hF) never passes.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    pass = 1'b0;
    case (cond_e'(cond))
      EQ: pass = z;
      NE: pass = ~z;
      CS: pass = c;
      CC: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = ~z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_ctrl_pipe.sv
// E/M/W control pipeline with condition check, grouped NZCV register and
// saturating annul/retire counters. D->E->M->W one cycle each; stall_e holds E.
module cond_ctrl_pipe
  import cond_pkg::*;
#(
  parameter int FLAG_GROUPS = 2,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_e,
  input  logic                   flush_e,
  input  logic                   valid_d,
  input  logic [3:0]             cond_d,
  input  logic                   pcs_d,
  input  logic                   regwrite_d,
  input  logic                   memwrite_d,
  input  logic                   memtoreg_d,
  input  logic                   branch_d,
  input  logic                   bl_d,
  input  logic                   byteen_d,
  input  logic                   alusrc_d,
  input  logic [3:0]             alucontrol_d,
  input  logic [FLAG_GROUPS-1:0] flagwrite_d,
  input  logic [3:0]             wa_d,
  input  logic [3:0]             aluflags_e,
  output logic [3:0]             alucontrol_e,
  output logic                   alusrc_e,
  output logic                   condex_e,
  output logic                   pcsrc_e,
  output logic [3:0]             flags,
  output logic                   regwrite_m,
  output logic                   memwrite_m,
  output logic                   memtoreg_m,
  output logic                   byteen_m,
  output logic                   pcs_m,
  output logic                   bl_m,
  output logic [3:0]             wa_m,
  output logic                   regwrite_w,
  output logic                   memtoreg_w,
  output logic                   pcs_w,
  output logic                   bl_w,
  output logic [3:0]             wa_w,
  output logic [CNT_W-1:0]       annul_cnt,
  output logic [CNT_W-1:0]       retire_cnt
);

  localparam int GW = 4 / FLAG_GROUPS;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ctrl_t                  d_ctrl;
  ctrl_t                  e_q, e_d, m_q, m_d, w_q, w_d;
  logic [FLAG_GROUPS-1:0] fw_e_q, fw_e_d;
  logic [3:0]             flags_q, flags_d, bit_we;
  logic [CNT_W-1:0]       annul_q, annul_d, retire_q, retire_d;
  logic                   pass_e, flag_we;

  always_comb begin
    d_ctrl            = CTRL_BUBBLE;
    d_ctrl.valid      = valid_d;
    d_ctrl.pcs        = pcs_d;
    d_ctrl.regwrite   = regwrite_d;
    d_ctrl.memwrite   = memwrite_d;
    d_ctrl.memtoreg   = memtoreg_d;
    d_ctrl.branch     = branch_d;
    d_ctrl.bl         = bl_d;
    d_ctrl.byteen     = byteen_d;
    d_ctrl.alusrc     = alusrc_d;
    d_ctrl.alucontrol = alucontrol_d;
    d_ctrl.cond       = cond_e'(cond_d);
    d_ctrl.wa         = wa_d;
  end

  // Flush outranks stall so a squashed instruction cannot linger in E.
  always_comb begin
    e_d    = e_q;
    fw_e_d = fw_e_q;
    if (flush_e) begin
      e_d    = CTRL_BUBBLE;
      fw_e_d = '0;
    end else if (!stall_e) begin
      e_d    = d_ctrl;
      fw_e_d = flagwrite_d;
    end
  end

  cond_check u_cond_check (
    .cond  (e_q.cond),
    .flags (flags_q),
    .pass  (pass_e)
  );

  assign condex_e     = e_q.valid & pass_e;
  assign pcsrc_e      = condex_e & (e_q.branch | e_q.pcs);
  assign alucontrol_e = e_q.alucontrol;
  assign alusrc_e     = e_q.alusrc;

  always_comb begin
    m_d = CTRL_BUBBLE;
    if (!stall_e) begin
      m_d          = e_q;
      m_d.regwrite = e_q.regwrite & condex_e;
      m_d.memwrite = e_q.memwrite & condex_e;
      m_d.pcs      = e_q.pcs & condex_e;
      m_d.bl       = e_q.bl & condex_e;
    end
  end

  assign w_d = m_q;

  // A stalled E stays put, so it must not commit flags until it leaves.
  assign flag_we = condex_e & ~stall_e;

  for (genvar i = 0; i < 4; i++) begin : g_flag_bit
    assign bit_we[i] = flag_we & fw_e_q[i / GW];
  end

  assign flags_d = (aluflags_e & bit_we) | (flags_q & ~bit_we);

  always_comb begin
    annul_d  = annul_q;
    retire_d = retire_q;
    if (e_q.valid && !pass_e && !stall_e && !(&annul_q)) annul_d = annul_q + CNT_ONE;
    if (w_q.valid && !(&retire_q)) retire_d = retire_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q      <= CTRL_BUBBLE;
      m_q      <= CTRL_BUBBLE;
      w_q      <= CTRL_BUBBLE;
      fw_e_q   <= '0;
      flags_q  <= 4'b0000;
      annul_q  <= '0;
      retire_q <= '0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_q      <= w_d;
      fw_e_q   <= fw_e_d;
      flags_q  <= flags_d;
      annul_q  <= annul_d;
      retire_q <= retire_d;
    end
  end

  assign flags      = flags_q;
  assign regwrite_m = m_q.regwrite;
  assign memwrite_m = m_q.memwrite;
  assign memtoreg_m = m_q.memtoreg;
  assign byteen_m   = m_q.byteen;
  assign pcs_m      = m_q.pcs;
  assign bl_m       = m_q.bl;
  assign wa_m       = m_q.wa;
  assign regwrite_w = w_q.regwrite;
  assign memtoreg_w = w_q.memtoreg;
  assign pcs_w      = w_q.pcs;
  assign bl_w       = w_q.bl;
  assign wa_w       = w_q.wa;
  assign annul_cnt  = annul_q;
  assign retire_cnt = retire_q;

  logic unused_w;
  assign unused_w = ^{w_q.memwrite, w_q.branch, w_q.byteen, w_q.alusrc,
                      w_q.alucontrol, w_q.cond};

endmodule

// File: tb/tb_cond_ctrl_pipe.sv
// Directed bench for cond_ctrl_pipe: expected W-stage records are queued at issue
// and popped by a monitor whenever a real instruction (wa != 0) is at W.
module tb_cond_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset, stall_e, flush_e, valid_d;
  logic [3:0] cond_d, alucontrol_d, wa_d, aluflags_e;
  logic       pcs_d, regwrite_d, memwrite_d, memtoreg_d, branch_d, bl_d, byteen_d, alusrc_d;
  logic [1:0] flagwrite_d;
  logic [3:0] alucontrol_e, flags, wa_m, wa_w;
  logic       alusrc_e, condex_e, pcsrc_e;
  logic       regwrite_m, memwrite_m, memtoreg_m, byteen_m, pcs_m, bl_m;
  logic       regwrite_w, memtoreg_w, pcs_w, bl_w;
  logic [3:0] annul_cnt, retire_cnt;

  localparam logic [3:0] C_NE = 4'h1, C_GE = 4'hA, C_AL = 4'hE;

  typedef struct packed {
    logic       rw;
    logic       mtr;
    logic       pcs;
    logic       bl;
    logic [3:0] wa;
  } wexp_t;

  wexp_t wq[$];
  wexp_t mon_e;
  int    checks   = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  cond_ctrl_pipe #(.FLAG_GROUPS(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d), .cond_d(cond_d), .pcs_d(pcs_d), .regwrite_d(regwrite_d),
    .memwrite_d(memwrite_d), .memtoreg_d(memtoreg_d), .branch_d(branch_d), .bl_d(bl_d),
    .byteen_d(byteen_d), .alusrc_d(alusrc_d), .alucontrol_d(alucontrol_d),
    .flagwrite_d(flagwrite_d), .wa_d(wa_d), .aluflags_e(aluflags_e),
    .alucontrol_e(alucontrol_e), .alusrc_e(alusrc_e), .condex_e(condex_e),
    .pcsrc_e(pcsrc_e), .flags(flags), .regwrite_m(regwrite_m), .memwrite_m(memwrite_m),
    .memtoreg_m(memtoreg_m), .byteen_m(byteen_m), .pcs_m(pcs_m), .bl_m(bl_m),
    .wa_m(wa_m), .regwrite_w(regwrite_w), .memtoreg_w(memtoreg_w), .pcs_w(pcs_w),
    .bl_w(bl_w), .wa_w(wa_w), .annul_cnt(annul_cnt), .retire_cnt(retire_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && wa_w != 4'd0) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w_unexpected got_wa=%0h exp=none", wa_w);
      end else begin
        mon_e = wq.pop_front();
        chk("w_stage", 32'({regwrite_w, memtoreg_w, pcs_w, bl_w, wa_w}), 32'(mon_e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [3:0] cond, input logic rw, input logic mw,
                     input logic br, input logic bl, input logic [1:0] fw, input logic [3:0] wa);
    valid_d = v; cond_d = cond; regwrite_d = rw; memwrite_d = mw; memtoreg_d = 1'b0;
    branch_d = br; bl_d = bl; pcs_d = 1'b0; byteen_d = 1'b0; alusrc_d = 1'b1;
    alucontrol_d = 4'h2; flagwrite_d = fw; wa_d = wa;
  endtask

  task automatic bubble();
    drv(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0);
    alusrc_d = 1'b0;
    alucontrol_d = 4'h0;
  endtask

  task automatic push(input logic rw, input logic pcs, input logic bl, input logic [3:0] wa);
    wq.push_back('{rw: rw, mtr: 1'b0, pcs: pcs, bl: bl, wa: wa});
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ctrl"}, 32'({alusrc_e, condex_e, pcsrc_e, regwrite_m, memwrite_m, memtoreg_m,
                              byteen_m, pcs_m, bl_m, regwrite_w, memtoreg_w, pcs_w, bl_w}), 32'd0);
    chk({tag, "_flags"}, 32'(flags), 32'd0);
    chk({tag, "_wa"}, 32'({alucontrol_e, wa_m, wa_w}), 32'd0);
    chk({tag, "_cnt"}, 32'({annul_cnt, retire_cnt}), 32'd0);
  endtask

  task automatic run_table(input logic [3:0] setf, input logic [15:0] exp, input logic [3:0] exp_annul);
    drv(1'b1, C_AL, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'hF);
    push(1'b0, 1'b0, 1'b0, 4'hF);
    step();
    aluflags_e = setf;
    drv(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'h9);
    push(exp[0], 1'b0, 1'b0, 4'h9);
    for (int c = 0; c < 16; c++) begin
      step();
      chk($sformatf("condex_f%0h_c%0h", setf, c), 32'(condex_e), 32'(exp[c]));
      if (c < 15) begin
        drv(1'b1, 4'(c + 1), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'h9);
        push(exp[c + 1], 1'b0, 1'b0, 4'h9);
      end else begin
        bubble();
      end
    end
    repeat (3) step();
    chk($sformatf("annul_after_f%0h", setf), 32'(annul_cnt), 32'(exp_annul));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; stall_e = 1'b0; flush_e = 1'b0; aluflags_e = 4'h0;
    bubble();
    repeat (2) step();
    reset_checks("init");
    reset = 1'b1;

    // Reset with two instructions in flight and flags already written.
    drv(1'b1, C_AL, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'hA);
    step();
    aluflags_e = 4'hF;
    drv(1'b1, C_AL, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 4'hB);
    step();
    chk("pre_rst_flags", 32'(flags), 32'hF);
    chk("pre_rst_wa_m", 32'(wa_m), 32'hA);
    reset = 1'b0;
    #2;
    reset_checks("mid");
    bubble();
    aluflags_e = 4'h0;
    step();
    reset_checks("held");
    reset = 1'b1;

    // CMP sets Z, then ADD NE is annulled.
    drv(1'b1, C_AL, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'h1);
    push(1'b0, 1'b0, 1'b0, 4'h1);
    step();
    chk("alucontrol_e", 32'(alucontrol_e), 32'h2);
    chk("alusrc_e", 32'(alusrc_e), 32'h1);
    aluflags_e = 4'b0100;
    drv(1'b1, C_NE, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'h2);
    push(1'b0, 1'b0, 1'b0, 4'h2);
    step();
    chk("cmp_flags", 32'(flags), 32'b0100);
    chk("add_condex", 32'(condex_e), 32'h0);
    aluflags_e = 4'h0;
    bubble();
    step();
    chk("add_regwrite_m", 32'(regwrite_m), 32'h0);
    chk("add_wa_m", 32'(wa_m), 32'h2);
    chk("annul_one", 32'(annul_cnt), 32'h1);
    step();
    chk("retire_one", 32'(retire_cnt), 32'h1);

    // Partial group write: only C,V cleared.
    drv(1'b1, C_AL, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'h3);
    push(1'b0, 1'b0, 1'b0, 4'h3);
    step();
    aluflags_e = 4'hF;
    drv(1'b1, C_AL, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 4'h4);
    push(1'b1, 1'b0, 1'b0, 4'h4);
    step();
    chk("flags_all_set", 32'(flags), 32'hF);
    aluflags_e = 4'h0;
    bubble();
    step();
    chk("flags_group0", 32'(flags), 32'b1100);

    // Branch GE: taken with N=V=1, not taken with N=1,V=0.
    drv(1'b1, C_AL, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'hC);
    push(1'b0, 1'b0, 1'b0, 4'hC);
    step();
    aluflags_e = 4'b1001;
    drv(1'b1, C_GE, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 4'hE);
    push(1'b1, 1'b0, 1'b1, 4'hE);
    step();
    chk("flags_nv", 32'(flags), 32'b1001);
    chk("pcsrc_taken", 32'(pcsrc_e), 32'h1);
    aluflags_e = 4'b1000;
    drv(1'b1, C_AL, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'hC);
    push(1'b0, 1'b0, 1'b0, 4'hC);
    step();
    drv(1'b1, C_GE, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 4'hD);
    push(1'b0, 1'b0, 1'b0, 4'hD);
    step();
    chk("flags_n", 32'(flags), 32'b1000);
    chk("pcsrc_not_taken", 32'(pcsrc_e), 32'h0);
    bubble();
    step();

    // Two-cycle stall with a flag setter in E.
    drv(1'b1, C_AL, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'h6);
    push(1'b1, 1'b0, 1'b0, 4'h6);
    step();
    aluflags_e = 4'b0110;
    stall_e = 1'b1;
    drv(1'b1, C_AL, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'h7);
    push(1'b1, 1'b0, 1'b0, 4'h7);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("stall%0d_flags", k), 32'(flags), 32'b1000);
      chk($sformatf("stall%0d_m_bubble", k), 32'({regwrite_m, wa_m}), 32'h0);
      chk($sformatf("stall%0d_condex", k), 32'(condex_e), 32'h1);
    end
    stall_e = 1'b0;
    step();
    chk("release_flags", 32'(flags), 32'b0110);
    chk("release_wa_m", 32'(wa_m), 32'h6);
    bubble();
    step();

    // Stall and flush together: bubble wins, instruction is dropped.
    drv(1'b1, C_AL, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'h8);
    step();
    chk("pre_flush_condex", 32'(condex_e), 32'h1);
    stall_e = 1'b1;
    flush_e = 1'b1;
    bubble();
    step();
    chk("flush_condex", 32'(condex_e), 32'h0);
    chk("flush_alusrc", 32'(alusrc_e), 32'h0);
    chk("flush_m_bubble", 32'(wa_m), 32'h0);
    stall_e = 1'b0;
    flush_e = 1'b0;
    step();

    // All sixteen conditions against two flag patterns; annul count saturates.
    run_table(4'b0110, 16'b0110_0110_1010_0101, 4'd10);
    run_table(4'b1001, 16'b0101_0110_0101_1010, 4'd15);

    repeat (4) step();
    chk("retire_sat", 32'(retire_cnt), 32'hF);
    chk("annul_sat", 32'(annul_cnt), 32'hF);
    chk("queue_empty", 32'(wq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
